// File: rtl/timer_pkg.sv
// Shared types and constants for the microwave mm:ss countdown.
// Quick-start preset is enabled by MICROWAVE_QUICKSTART_EN in the top.
package timer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENTRY = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int DIGIT_W = 4;

    localparam logic [4*DIGIT_W-1:0] BCD_ZERO = '0;
    localparam logic [4*DIGIT_W-1:0] BCD_ONE  = 16'h0001;

    localparam int MOD_DEC = 10;
    localparam int MOD_SIX = 6;

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of the down-counter chain; wraps 0 -> MOD-1 and
// raises borrow_out when decremented from zero.
module bcd_digit_down
    import timer_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               en,
    input  logic               load,
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] q,
    output logic               borrow_out
);

    localparam logic [DIGIT_W-1:0] TOP = DIGIT_W'(MOD - 1);

    assign borrow_out = en & (q == '0);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (en) begin
            q <= (q == '0) ? TOP : q - 1'b1;
        end
    end

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Microwave countdown sequencer: key entry, run/pause/clear, door gating.
// Define MICROWAVE_QUICKSTART_EN to let start in IDLE load QUICK_TIME.
module microwave_timer_ctrl
    import timer_pkg::*;
#(
    parameter logic [15:0] QUICK_TIME = 16'h0030
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         tick,
    input  logic         key_valid,
    input  logic [3:0]   key_digit,
    input  logic         start,
    input  logic         stop_clear,
    input  logic         door_closed,
    output logic [15:0]  digits,
    output logic         heat,
    output logic         done,
    output logic         key_err,
    output logic [2:0]   state
);

`ifdef MICROWAVE_QUICKSTART_EN
    localparam bit QS_EN = 1'b1;
`else
    localparam bit QS_EN = 1'b0;
`endif

    state_t       st;
    state_t       nst;
    logic         load;
    logic         dec;
    logic         rej;
    logic [15:0]  ldata;
    logic [3:0]   bo;
    logic         key_ok;
    logic         door_ev;
    logic         unused_bo;

    assign key_ok    = key_valid && (key_digit <= 4'd9);
    // An open door only counts as an event while cooking.
    assign door_ev   = (st == RUN) && !door_closed;
    assign unused_bo = bo[3];
    assign state     = st;

    always_comb begin
        nst   = st;
        load  = 1'b0;
        dec   = 1'b0;
        rej   = 1'b0;
        ldata = digits;
        if (door_ev) begin
            nst = PAUSE;
        end else if (stop_clear) begin
            if (st == RUN) begin
                nst = PAUSE;
            end else if (st != IDLE) begin
                nst   = IDLE;
                load  = 1'b1;
                ldata = BCD_ZERO;
            end
        end else if (start) begin
            if ((st == ENTRY || st == PAUSE)
                && door_closed && digits != BCD_ZERO) begin
                nst = RUN;
            end else if (st == IDLE && QS_EN && door_closed) begin
                nst   = RUN;
                load  = 1'b1;
                ldata = QUICK_TIME;
            end
        end else if (key_ok) begin
            if (st == DONE) begin
                nst   = ENTRY;
                load  = 1'b1;
                ldata = {12'h000, key_digit};
            end else if (st == IDLE || st == ENTRY) begin
                if (digits[3:0] > 4'd5) begin
                    rej = 1'b1;
                end else begin
                    nst   = ENTRY;
                    load  = 1'b1;
                    ldata = {digits[11:0], key_digit};
                end
            end
        end else if (tick && st == RUN) begin
            dec = 1'b1;
            if (digits == BCD_ONE) begin
                nst = DONE;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            st      <= IDLE;
            heat    <= 1'b0;
            done    <= 1'b0;
            key_err <= 1'b0;
        end else begin
            st      <= nst;
            heat    <= (nst == RUN);
            done    <= (nst == DONE);
            key_err <= rej;
        end
    end

    bcd_digit_down #(.MOD(MOD_DEC)) u_sec_ones (
        .clk        (clk),
        .clr        (clr),
        .en         (dec),
        .load       (load),
        .din        (ldata[3:0]),
        .q          (digits[3:0]),
        .borrow_out (bo[0])
    );

    bcd_digit_down #(.MOD(MOD_SIX)) u_sec_tens (
        .clk        (clk),
        .clr        (clr),
        .en         (bo[0]),
        .load       (load),
        .din        (ldata[7:4]),
        .q          (digits[7:4]),
        .borrow_out (bo[1])
    );

    bcd_digit_down #(.MOD(MOD_DEC)) u_min_ones (
        .clk        (clk),
        .clr        (clr),
        .en         (bo[1]),
        .load       (load),
        .din        (ldata[11:8]),
        .q          (digits[11:8]),
        .borrow_out (bo[2])
    );

    bcd_digit_down #(.MOD(MOD_DEC)) u_min_tens (
        .clk        (clk),
        .clr        (clr),
        .en         (bo[2]),
        .load       (load),
        .din        (ldata[15:12]),
        .q          (digits[15:12]),
        .borrow_out (bo[3])
    );

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Bench for microwave_timer_ctrl: seconds-based reference model,
// directed scenarios with literal pins, then randomized traffic.
module tb_microwave_timer_ctrl;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ENTRY = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

`ifdef MICROWAVE_QUICKSTART_EN
    localparam bit QS = 1'b1;
`else
    localparam bit QS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr;
    logic        tick;
    logic        key_valid;
    logic [3:0]  key_digit;
    logic        start;
    logic        stop_clear;
    logic        door_closed;
    logic [15:0] digits;
    logic        heat;
    logic        done;
    logic        key_err;
    logic [2:0]  state;

    int vectors = 0;
    int miscompares = 0;

    // reference model: time held as plain minutes and seconds
    int         mm = 0;
    int         ss = 0;
    int         t;
    logic [2:0] mst = S_IDLE;
    logic       mkerr = 1'b0;

    microwave_timer_ctrl dut (
        .clk         (clk),
        .clr         (clr),
        .tick        (tick),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .start       (start),
        .stop_clear  (stop_clear),
        .door_closed (door_closed),
        .digits      (digits),
        .heat        (heat),
        .done        (done),
        .key_err     (key_err),
        .state       (state)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] bcd(input int m, input int s);
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (clr) begin
            mm = 0; ss = 0; mst = S_IDLE; mkerr = 1'b0;
        end else begin
            mkerr = 1'b0;
            if (mst == S_RUN && !door_closed) begin
                mst = S_PAUSE;
            end else if (stop_clear) begin
                if (mst == S_RUN) mst = S_PAUSE;
                else if (mst != S_IDLE) begin
                    mst = S_IDLE; mm = 0; ss = 0;
                end
            end else if (start) begin
                if ((mst == S_ENTRY || mst == S_PAUSE) && door_closed
                    && (mm + ss) != 0)
                    mst = S_RUN;
                else if (mst == S_IDLE && QS && door_closed) begin
                    mst = S_RUN; mm = 0; ss = 30;
                end
            end else if (key_valid && key_digit <= 9) begin
                if (mst == S_DONE) begin
                    mm = 0; ss = int'(key_digit); mst = S_ENTRY;
                end else if (mst == S_IDLE || mst == S_ENTRY) begin
                    if (ss % 10 > 5) mkerr = 1'b1;
                    else begin
                        mm = (mm % 10) * 10 + ss / 10;
                        ss = (ss % 10) * 10 + int'(key_digit);
                        mst = S_ENTRY;
                    end
                end
            end else if (tick && mst == S_RUN) begin
                t = mm * 60 + ss - 1;
                mm = t / 60; ss = t % 60;
                if (t == 0) mst = S_DONE;
            end
        end
        #1;
        if (!clr) begin
            chk("digits", 32'(digits), 32'(bcd(mm, ss)));
            chk("state", 32'(state), 32'(mst));
            chk("heat", 32'(heat), 32'(mst == S_RUN));
            chk("done", 32'(done), 32'(mst == S_DONE));
            chk("key_err", 32'(key_err), 32'(mkerr));
        end
    end

    task automatic cyc(input logic t_i, input logic kv, input logic [3:0] kd,
                       input logic s_i, input logic sc);
        tick = t_i; key_valid = kv; key_digit = kd;
        start = s_i; stop_clear = sc;
        @(negedge clk);
        tick = 0; key_valid = 0; start = 0; stop_clear = 0;
    endtask

    task automatic key(input logic [3:0] k);
        cyc(0, 1, k, 0, 0);
    endtask

    initial begin
        clr = 1; tick = 0; key_valid = 0; key_digit = 0;
        start = 0; stop_clear = 0; door_closed = 1;
        @(negedge clk); @(negedge clk);
        clr = 0;
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_state", 32'(state), 32'(S_IDLE));
        chk("rst_heat", 32'(heat), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_kerr", 32'(key_err), 32'h0);

        // entry and rejection
        key(1); key(3); key(0);
        chk("entry_0130", 32'(digits), 32'h0130);
        chk("entry_state", 32'(state), 32'(S_ENTRY));
        key(7);
        chk("entry_1307", 32'(digits), 32'h1307);
        key(2);
        chk("rej_kerr", 32'(key_err), 32'h1);
        chk("rej_digits", 32'(digits), 32'h1307);
        cyc(0, 0, 0, 0, 0);
        chk("rej_kerr_drop", 32'(key_err), 32'h0);

        // borrow chain
        cyc(0, 0, 0, 0, 1);
        chk("clr_idle", 32'(digits), 32'h0);
        key(1); key(0); key(0);
        cyc(0, 0, 0, 1, 0);
        chk("start_heat", 32'(heat), 32'h1);
        cyc(1, 0, 0, 0, 0);
        chk("borrow_0059", 32'(digits), 32'h0059);
        for (int i = 0; i < 59; i++) cyc(1, 0, 0, 0, 0);
        chk("fin_digits", 32'(digits), 32'h0);
        chk("fin_state", 32'(state), 32'(S_DONE));
        chk("fin_done", 32'(done), 32'h1);
        chk("fin_heat", 32'(heat), 32'h0);

        // door pause
        key(3);
        chk("done_key", 32'(digits), 32'h0003);
        key(0);
        cyc(0, 0, 0, 1, 0);
        door_closed = 0;
        cyc(1, 0, 0, 0, 0);
        chk("door_state", 32'(state), 32'(S_PAUSE));
        chk("door_digits", 32'(digits), 32'h0030);
        door_closed = 1;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        chk("resume_state", 32'(state), 32'(S_RUN));
        cyc(1, 0, 0, 0, 0);
        chk("resume_0029", 32'(digits), 32'h0029);

        // stop / clear
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        key(4); key(5);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        chk("stop_state", 32'(state), 32'(S_PAUSE));
        chk("stop_digits", 32'(digits), 32'h0045);
        cyc(0, 0, 0, 0, 1);
        chk("clear_state", 32'(state), 32'(S_IDLE));
        chk("clear_digits", 32'(digits), 32'h0);
        cyc(0, 0, 0, 1, 0);
`ifdef MICROWAVE_QUICKSTART_EN
        chk("qs_state", 32'(state), 32'(S_RUN));
        chk("qs_digits", 32'(digits), 32'h0030);
        cyc(1, 0, 0, 0, 0);
        chk("qs_0029", 32'(digits), 32'h0029);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
`else
        chk("nostart_state", 32'(state), 32'(S_IDLE));
        chk("nostart_heat", 32'(heat), 32'h0);
`endif

        // async reset mid-run
        key(5); key(1); key(2);
        cyc(0, 0, 0, 1, 0);
        chk("pre_rst_0512", 32'(digits), 32'h0512);
        #2 clr = 1;
        #1;
        chk("arst_heat", 32'(heat), 32'h0);
        chk("arst_digits", 32'(digits), 32'h0);
        chk("arst_state", 32'(state), 32'(S_IDLE));
        @(negedge clk);
        clr = 0;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) door_closed = ~door_closed;
            tick       = ($urandom_range(0, 2) == 0);
            key_valid  = ($urandom_range(0, 5) == 0);
            key_digit  = 4'($urandom_range(0, 15));
            start      = ($urandom_range(0, 9) == 0);
            stop_clear = ($urandom_range(0, 29) == 0);
            @(negedge clk);
        end
        tick = 0; key_valid = 0; start = 0; stop_clear = 0;
        door_closed = 1;
        @(negedge clk); @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/microwave_timer_ctrl.md
# microwave_timer_ctrl

Sequencer for the microwave's mm:ss countdown. It accepts keypad digits, loads them into a four-digit BCD down-counter chain, and runs, pauses, clears and finishes the countdown. It gates the countdown on the door interlock and produces the magnetron enable and the done indication. It sits between the keypad decoder / 1 Hz prescaler and the display and power-stage logic.

## Interface
- `QUICK_TIME`, default 16'h0030 — BCD mm:ss preset; used only when quick-start is compiled in.
- `clk` in 1 — system clock.
- `clr` in 1 — asynchronous, active-high reset.
- `tick` in 1 — one-cycle pulse, 1 Hz.
- `key_valid` in 1 — one-cycle strobe; `key_digit` is valid in that cycle.
- `key_digit` in 4 — keypad digit, 0–9; values 10–15 are ignored.
- `start` in 1 — start/resume strobe, one cycle.
- `stop_clear` in 1 — stop/clear strobe, one cycle.
- `door_closed` in 1 — interlock level; 1 = closed.
- `digits` out 16 — BCD {min_tens, min_ones, sec_tens, sec_ones}.
- `heat` out 1 — magnetron enable.
- `done` out 1 — countdown finished; level.
- `key_err` out 1 — one-cycle pulse when a key is rejected.
- `state` out 3 — FSM state, for debug and display.

## Operation
- **States:** IDLE, ENTRY, RUN, PAUSE, DONE.
- **Reset:** state = IDLE, `digits` = 0, `heat` = 0, `done` = 0, `key_err` = 0.
- **Key entry:** a valid key in IDLE or ENTRY shifts `digits` left one nibble and inserts the key at `sec_ones`. The old `min_tens` is discarded. State → ENTRY.
  - A key is rejected if the current `sec_ones` is > 5, because it would shift into `sec_tens`.
  - On rejection: `digits` unchanged, `key_err` pulses.
- **Keys in other states:** ignored in RUN and PAUSE. In DONE, a key clears `digits` to 0, applies the key as in IDLE, and goes to ENTRY.
- **start:**
  - From ENTRY or PAUSE: → RUN if `door_closed` = 1 and `digits` ≠ 0. Otherwise ignored.
  - From IDLE with `digits` = 0: no effect (see Configuration).
- **Countdown:** on `tick` in RUN, decrement `digits` with borrow.
  - `sec_ones`: modulo 10, 0 → 9.
  - `sec_tens`: modulo 6, 0 → 5.
  - `min_ones`: modulo 10.
  - `min_tens`: modulo 10.
  - A borrow propagates only when the lower digit is 0.
- **Finish:** the decrement that reaches 0000 moves to DONE on the same edge.
- **Door:** `door_closed` = 0 in RUN → PAUSE. `digits` are held.
- **stop_clear:**
  - In RUN → PAUSE.
  - In ENTRY, PAUSE or DONE → IDLE with `digits` = 0.
  - In IDLE: no effect.
- **Outputs:** `heat` = (state == RUN). `done` = (state == DONE).
- **Priority within one cycle:** `clr` > door open > `stop_clear` > `start` > key > `tick`. Lower-priority events in the same cycle are dropped, not queued.

## Timing
- All state and `digits` updates are registered on the `clk` rising edge. `heat`, `done` and `state` decode from registers, with no combinational path from inputs.
- `start` at edge N: `heat` = 1 after edge N. A `tick` in the same cycle as `start` is ignored; the first decrement happens at the next tick.
- `tick` with `digits` = 0001 at edge N: after edge N, `digits` = 0000, state = DONE, `heat` = 0, `done` = 1.
- Door opens with `tick` in the same cycle: no decrement; state → PAUSE.
- `key_err` is high for exactly the cycle after the rejected strobe.
- `clr` asserted mid-run: all outputs go to their reset values asynchronously, with no wait for the clock.

## Configuration
- `MICROWAVE_QUICKSTART_EN`
  - **Defined:** `start` in IDLE loads `QUICK_TIME` into `digits` and enters RUN on the same edge, provided `door_closed` = 1.
  - **Undefined:** `start` in IDLE has no effect.

## Structure
- Package `timer_pkg` contains:
  - the state enum (IDLE, ENTRY, RUN, PAUSE, DONE) with 3-bit encoding;
  - the `DIGIT_W` = 4 constant;
  - the BCD zero constant and the digit modulo constants (10, 6).
- Sub-module `bcd_digit_down`:
  - parameters: modulo `MOD`;
  - ports: `en` (borrow in), `load`, `din`, `q`, `borrow_out`, where `borrow_out` = `en` & (`q` == 0);
  - instantiated four times, as the chain 10, 6, 10, 10.
- The controller FSM, key shifting and priority logic live in `microwave_timer_ctrl`.

## Test plan
- **Entry and rejection:** keys 1, 3, 0 → `digits` = 0130. Then key 7 → `digits` = 1307. Then key 2 → rejected (`sec_ones` = 7 > 5), `key_err` pulse, `digits` = 1307.
- **Borrow chain:** `digits` = 0100, `start`, 1 tick → 0059, `heat` = 1. After 59 more ticks → 0000, state = DONE, `done` = 1, `heat` = 0.
- **Door pause:** RUN at 0030, door opens with a simultaneous tick → PAUSE, `digits` = 0030. Door closes, then `start` → RUN and the next tick gives 0029.
- **Stop/clear:** RUN at 0045 → `stop_clear` → PAUSE at 0045. Second `stop_clear` → IDLE, `digits` = 0000. `start` with 0000 → no change (macro off).
- **Async reset:** assert `clr` mid-RUN at 0512 → `heat` = 0, `digits` = 0000, state = IDLE before the next clock edge.
- **Quick-start:** with `MICROWAVE_QUICKSTART_EN`, `start` in IDLE → RUN at 0030. After 1 tick → 0029.
